mc_pi_estimator: RTL and testbench

// - Downstream consumer of the 32-bit xorshift PRNG word stream: Monte Carlo estimate of pi.
// - Each accepted word is one sample point: x = rnd[31:16] and y = rnd[15:0], both unsigned.
// - A sample is a hit when x^2 + y^2 < 2^32, i.e. the point is inside the quarter circle.
// - Counts hits over 2^SAMPLES_LOG2 samples. Reports hits and pi_est = 4*hits / 2^SAMPLES_LOG2.

---
 rtl/mc_pi_pkg.sv | 20 ++
 rtl/mc_pi_estimator_if.sv | 24 ++
 rtl/mc_pi_datapath.sv | 46 ++++
 rtl/mc_pi_estimator.sv | 111 +++++++++++
 tb/tb_mc_pi_estimator.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pi_pkg.sv
// Shared types and constants for the Monte Carlo pi estimator.
package mc_pi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Register stages between sample injection and the inside/outside flag.
    localparam int PIPE_DEPTH = 3;

    // Where the two 16-bit coordinates sit inside a PRNG word.
    localparam int X_MSB = 31;
    localparam int X_LSB = 16;
    localparam int Y_MSB = 15;
    localparam int Y_LSB = 0;

endpackage

// File: rtl/mc_pi_estimator_if.sv
// Sample stream in, run control and results out, for the pi estimator.
interface mc_pi_estimator_if #(
    parameter int SAMPLES_LOG2 = 16
);
    logic [31:0]             rnd;
    logic                    rnd_valid;
    logic                    start;
    logic                    busy;
    logic                    done;
    logic [SAMPLES_LOG2:0]   hits;
    logic [SAMPLES_LOG2+2:0] pi_est;

    // Producer side: PRNG feed plus run request; observes the results.
    modport master (
        output rnd, rnd_valid, start,
        input  busy, done, hits, pi_est
    );

    // Estimator side.
    modport slave (
        input  rnd, rnd_valid, start,
        output busy, done, hits, pi_est
    );
endinterface

// File: rtl/mc_pi_datapath.sv
// Three-stage sample pipeline: split word, square coordinates, test x^2+y^2 < 2^32.
module mc_pi_datapath
    import mc_pi_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_word,
    output logic        out_valid,
    output logic        out_inside
);

    logic        s1_valid, s2_valid, s3_valid;
    logic [15:0] s1_x, s1_y;
    logic [31:0] s2_xx, s2_yy;
    logic        s3_inside;

    // Valid bits advance one stage per clock; reset empties the pipeline.
    // NOTE: sequential state uses non-blocking assignments so each stage samples the pre-edge value of the stage before it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
        end
    end

    // Payload stages; the 33-bit sum xx+yy carries out exactly when yy > ~xx,
    // so the inside flag is formed without materialising the unused low sum bits.
    // NOTE: payload registers are deliberately left out of reset: they are only ever read alongside their valid bit, which is reset.
    always_ff @(posedge clk) begin
        s1_x      <= in_word[X_MSB:X_LSB];
        s1_y      <= in_word[Y_MSB:Y_LSB];
        s2_xx     <= 32'(s1_x) * 32'(s1_x);
        s2_yy     <= 32'(s1_y) * 32'(s1_y);
        s3_inside <= (s2_yy <= ~s2_xx);
    end

    assign out_valid  = s3_valid;
    assign out_inside = s3_inside;

endmodule

// File: rtl/mc_pi_estimator.sv
// Monte Carlo pi estimator: counts quarter-circle hits over 2^SAMPLES_LOG2 PRNG samples.
module mc_pi_estimator
    import mc_pi_pkg::*;
#(
    parameter int SAMPLES_LOG2 = 16
) (
    input  logic               clk,
    input  logic               reset,
    mc_pi_estimator_if.slave   bus
);

    localparam int             CW         = SAMPLES_LOG2 + 1;
    localparam logic [CW-1:0]  LAST_IDX   = CW'((1 << SAMPLES_LOG2) - 1);
    // Drain covers the pipeline stages plus the accumulator's own register,
    // so the last hit is in the accumulator when the count reaches PIPE_DEPTH.
    localparam logic [1:0]     DRAIN_LAST = 2'(PIPE_DEPTH);

    state_e         state, next_state;
    logic [CW-1:0]  issue_cnt;
    logic [1:0]     drain_cnt;
    logic [CW-1:0]  acc;
    logic [CW-1:0]  hits_q;
    logic           run_start, inject, load_result;
    logic           dp_valid, dp_inside;

    mc_pi_datapath u_datapath (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (inject),
        .in_word    (bus.rnd),
        .out_valid  (dp_valid),
        .out_inside (dp_inside)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state decode and the per-cycle control strobes.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
        next_state  = state;
        run_start   = 1'b0;
        inject      = 1'b0;
        load_result = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = RUN;
                    run_start  = 1'b1;
                end
            end
            RUN: begin
                if (bus.rnd_valid) begin
                    inject = 1'b1;
                    if (issue_cnt == LAST_IDX) next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    next_state  = DONE;
                    load_result = 1'b1;
                end
            end
            DONE: begin
                if (bus.start) begin
                    next_state = RUN;
                    run_start  = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Issue counter: samples injected so far in this run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          issue_cnt <= '0;
        else if (run_start) issue_cnt <= '0;
        else if (inject)    issue_cnt <= issue_cnt + 1'b1;
    end

    // Drain counter: cycles spent in DRAIN, cleared everywhere else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               drain_cnt <= '0;
        else if (state == DRAIN) drain_cnt <= drain_cnt + 2'd1;
        else                     drain_cnt <= '0;
    end

    // Hit accumulator: one count per retiring sample that lands inside.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      acc <= '0;
        else if (run_start)             acc <= '0;
        else if (dp_valid && dp_inside) acc <= acc + 1'b1;
    end

    // Result register: holds the last completed run until the next one finishes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            hits_q <= '0;
        else if (load_result) hits_q <= acc;
    end

    assign bus.busy   = (state == RUN) || (state == DRAIN);
    assign bus.done   = (state == DONE);
    assign bus.hits   = hits_q;
    assign bus.pi_est = {hits_q, 2'b00};

endmodule

// File: tb/tb_mc_pi_estimator.sv
// Scoreboard bench for mc_pi_estimator: a small run (SAMPLES_LOG2=4) for control and
// edge cases, and a full-size run (SAMPLES_LOG2=16) fed from an xorshift32 model.
module tb_mc_pi_estimator;

    localparam int SL     = 4;
    localparam int NS     = 1 << SL;
    localparam int HW     = SL + 1;
    localparam int PW     = SL + 3;
    localparam int SL_BIG = 16;
    localparam int NS_BIG = 1 << SL_BIG;
    localparam int LAT    = 4;     // edges from last injection to the done cycle

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_pi_estimator_if #(.SAMPLES_LOG2(SL))     bus4  ();
    mc_pi_estimator_if #(.SAMPLES_LOG2(SL_BIG)) bus16 ();

    mc_pi_estimator #(.SAMPLES_LOG2(SL))     dut     (.clk(clk), .reset(reset), .bus(bus4));
    mc_pi_estimator #(.SAMPLES_LOG2(SL_BIG)) dut_big (.clk(clk), .reset(reset), .bus(bus16));

    int vectors    = 0;
    int miscompares = 0;
    int n;                 // edges since the start-accepting edge of the current run
    int exp_q[$];          // expected hit counts, one per fully fed run

    // Reference: point inside the quarter circle, computed in 64-bit arithmetic.
    function automatic bit model_hit(input logic [31:0] w);
        longint unsigned x, y;
        x = {48'd0, w[31:16]};
        y = {48'd0, w[15:0]};
        return (x * x + y * y) < 64'h1_0000_0000;
    endfunction

    function automatic logic [31:0] xorshift32(input logic [31:0] s);
        logic [31:0] v;
        v = s;
        v = v ^ (v << 13);
        v = v ^ (v >> 17);
        v = v ^ (v << 5);
        return v;
    endfunction

    // Pulse start for one cycle; returns just after the accepting edge with n=0.
    task automatic start_run4();
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        n = 0;
    endtask

    // Feed NS accepted samples, alternating w0/w1 (or random), optionally stalling every
    // third cycle and pulsing start on cycle start_at. Pushes the expected hit count.
    task automatic feed4(input logic [31:0] w0, input logic [31:0] w1, input bit use_rand,
                         input bit stall, input int start_at, output int stalls);
        int taken, cyc, h;
        taken = 0; cyc = 0; h = 0; stalls = 0;
        while (taken < NS) begin
            logic [31:0] w;
            bit          v;
            v = !(stall && (cyc % 3 == 2));
            w = use_rand ? $urandom : ((taken % 2 == 0) ? w0 : w1);
            bus4.rnd_valid = v;
            bus4.rnd       = v ? w : ~w;
            if (start_at >= 0) bus4.start = (cyc == start_at);
            if (v) begin
                h += int'(model_hit(w));
                taken++;
            end else begin
                stalls++;
            end
            cyc++;
            @(negedge clk);
            n++;
        end
        if (start_at >= 0) bus4.start = 1'b0;
        exp_q.push_back(h);
        // Valid-looking traffic during DRAIN must not be counted.
        bus4.rnd       = 32'hFFFF_FFFF;
        bus4.rnd_valid = 1'b1;
    endtask

    // Wait (bounded) for done, check its edge, then pop and check hits/pi_est.
    task automatic await_done4(input int exp_n, input string name);
        int          got;
        logic [HW-1:0] exp_hits;
        logic [PW-1:0] exp_pi;
        while (bus4.done !== 1'b1 && n < exp_n + 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (bus4.done !== 1'b1 || n != exp_n) begin
            miscompares++;
            $display("FAIL %s done_edge: done=%b at edge %0d, required done=1 at edge %0d",
                     name, bus4.done, n, exp_n);
        end
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s scoreboard: no expected entry queued", name);
        end else begin
            got      = exp_q.pop_front();
            exp_hits = HW'(got);
            exp_pi   = PW'(got * 4);
            if (bus4.hits !== exp_hits) begin
                miscompares++;
                $display("FAIL %s hits: got %0d, required %0d", name, bus4.hits, exp_hits);
            end
            vectors++;
            if (bus4.pi_est !== exp_pi) begin
                miscompares++;
                $display("FAIL %s pi_est: got %0d, required %0d", name, bus4.pi_est, exp_pi);
            end
        end
    endtask

    // Confirm done is a single-cycle pulse and the block returns to idle.
    task automatic check_back_to_idle(input string name);
        @(negedge clk);
        n++;
        vectors++;
        if (bus4.done !== 1'b0 || bus4.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after_done: done=%b busy=%b, required done=0 busy=0",
                     name, bus4.done, bus4.busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus4.start = 1'b0;  bus4.rnd_valid = 1'b0;  bus4.rnd = 32'h0;
        bus16.start = 1'b0; bus16.rnd_valid = 1'b0; bus16.rnd = 32'h0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus4.busy, bus4.done, bus4.hits, bus4.pi_est} !== '0) begin
            miscompares++;
            $display("FAIL reset_values: busy=%b done=%b hits=%0d pi_est=%0d, required all 0",
                     bus4.busy, bus4.done, bus4.hits, bus4.pi_est);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus4.busy !== 1'b0 || bus4.done !== 1'b0 || bus16.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_idle: busy=%b done=%b big_busy=%b, required 0",
                     bus4.busy, bus4.done, bus16.busy);
        end
    endtask

    // T1: all-zero samples, every one a hit; busy and done timing.
    task automatic test_all_hits();
        int stalls;
        bus4.rnd = 32'h0; bus4.rnd_valid = 1'b1;
        vectors++;
        if (bus4.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_busy_before: got %b, required 0", bus4.busy);
        end
        start_run4();
        vectors++;
        if (bus4.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL t1_busy_rise: got %b, required 1", bus4.busy);
        end
        feed4(32'h0, 32'h0, 1'b0, 1'b0, -1, stalls);
        await_done4(NS + LAT + stalls, "t1");
        check_back_to_idle("t1");
    endtask

    // T2: corner points, the circle boundary, and a random mix.
    task automatic test_misses_and_edges();
        int stalls;
        start_run4();
        feed4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, -1, stalls);
        await_done4(NS + LAT, "t2_all_miss");
        check_back_to_idle("t2_all_miss");
        start_run4();
        feed4(32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b0, -1, stalls);
        await_done4(NS + LAT, "t2_axis_hits");
        check_back_to_idle("t2_axis_hits");
        start_run4();
        feed4(32'hB504_B504, 32'hB505_B505, 1'b0, 1'b0, -1, stalls);
        await_done4(NS + LAT, "t2_boundary");
        check_back_to_idle("t2_boundary");
        start_run4();
        feed4(32'h0, 32'h0, 1'b1, 1'b0, -1, stalls);
        await_done4(NS + LAT, "t2_random");
        check_back_to_idle("t2_random");
    endtask

    // T3: alternating hit/miss with a bubble on every third cycle.
    task automatic test_stalls();
        int stalls;
        start_run4();
        feed4(32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1, -1, stalls);
        await_done4(NS + LAT + stalls, "t3_stalls");
        check_back_to_idle("t3_stalls");
    endtask

    // T4: start held through a run restarts from DONE; start while busy is ignored.
    task automatic test_back_to_back();
        int stalls;
        bit saw_activity;
        bus4.start = 1'b1;
        @(negedge clk);
        n = 0;
        feed4(32'h0, 32'h0, 1'b0, 1'b0, -1, stalls);
        await_done4(NS + LAT, "t4_run1");
        @(negedge clk);
        vectors++;
        if (bus4.busy !== 1'b1 || bus4.done !== 1'b0) begin
            miscompares++;
            $display("FAIL t4_restart_from_done: busy=%b done=%b, required busy=1 done=0",
                     bus4.busy, bus4.done);
        end
        n = 0;
        bus4.start = 1'b0;
        feed4(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 3, stalls);
        bus4.start = 1'b1;
        @(negedge clk);
        n++;
        bus4.start = 1'b0;
        await_done4(NS + LAT, "t4_run2");
        saw_activity = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus4.busy !== 1'b0 || bus4.done !== 1'b0) saw_activity = 1'b1;
        end
        vectors++;
        if (saw_activity) begin
            miscompares++;
            $display("FAIL t4_no_queued_start: busy or done seen after run2, required idle");
        end
    endtask

    // T5: asynchronous reset between edges aborts a run and clears the results.
    task automatic test_async_reset();
        int stalls;
        start_run4();
        feed4(32'h0, 32'h0, 1'b0, 1'b0, -1, stalls);
        await_done4(NS + LAT, "t5_prime");
        check_back_to_idle("t5_prime");
        start_run4();
        bus4.rnd = 32'h0; bus4.rnd_valid = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({bus4.busy, bus4.done, bus4.hits, bus4.pi_est} !== '0) begin
            miscompares++;
            $display("FAIL t5_async_clear: busy=%b done=%b hits=%0d pi_est=%0d, required all 0",
                     bus4.busy, bus4.done, bus4.hits, bus4.pi_est);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
            miscompares++;
            $display("FAIL t5_no_resume: busy=%b done=%b, required 0", bus4.busy, bus4.done);
        end
        start_run4();
        feed4(32'h0, 32'h0, 1'b0, 1'b0, -1, stalls);
        await_done4(NS + LAT, "t5_fresh");
        check_back_to_idle("t5_fresh");
    endtask

    // T6: full-size run fed from an xorshift32 stream.
    task automatic test_xorshift();
        logic [31:0]     s;
        int              h, got;
        logic [SL_BIG:0] exp_hits;
        s = 32'h2545_F491;
        h = 0;
        bus16.start = 1'b1;
        @(negedge clk);
        bus16.start = 1'b0;
        n = 0;
        for (int i = 0; i < NS_BIG; i++) begin
            s = xorshift32(s);
            bus16.rnd       = s;
            bus16.rnd_valid = 1'b1;
            h += int'(model_hit(s));
            @(negedge clk);
            n++;
        end
        exp_q.push_back(h);
        bus16.rnd_valid = 1'b0;
        while (bus16.done !== 1'b1 && n < NS_BIG + LAT + 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (bus16.done !== 1'b1 || n != NS_BIG + LAT) begin
            miscompares++;
            $display("FAIL t6 done_edge: done=%b at edge %0d, required at edge %0d",
                     bus16.done, n, NS_BIG + LAT);
        end
        got      = exp_q.pop_front();
        exp_hits = (SL_BIG + 1)'(got);
        vectors++;
        if (bus16.hits !== exp_hits) begin
            miscompares++;
            $display("FAIL t6 hits: got %0d, required %0d", bus16.hits, exp_hits);
        end
        vectors++;
        if (bus16.pi_est < 19'd203162 || bus16.pi_est > 19'd208404) begin
            miscompares++;
            $display("FAIL t6 pi_range: got %0d/65536, required 3.10..3.18", bus16.pi_est);
        end
    endtask

    initial begin
        test_reset();
        test_all_hits();
        test_misses_and_edges();
        test_stalls();
        test_back_to_back();
        test_async_reset();
        test_xorshift();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
